// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters (define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority)
`ifndef ALU_OSIZE
`define ALU_OSIZE [3:0]
`endif
`ifndef CPU_WSIZE
`define CPU_WSIZE [31:0]
`endif

module alu (
    output logic `CPU_WSIZE r,
    output logic            zero,
    output logic            ovf,
    input  logic `ALU_OSIZE op,
    input  logic `CPU_WSIZE a,
    input  logic `CPU_WSIZE b
);
    logic `CPU_WSIZE sum, dif;
    localparam int M = $bits(sum) - 1;
    assign sum = a + b;
    assign dif = a - b;
    assign zero = r == '0;
    assign ovf = (op == 2) ? (a[M] == b[M]) && (sum[M] != a[M]) :
                 (op == 3) ? (a[M] != b[M]) && (dif[M] != a[M]) : 1'b0;
    // opcode decode: 0 and, 1 or, 2 add, 3 sub, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 nor
    always_comb begin
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = sum;
            4'd3:    r = dif;
            4'd4:    r = a ^ b;
            4'd5:    r = {{M{1'b0}}, $signed(a) < $signed(b)};
            4'd6:    r = a << b[4:0];
            4'd7:    r = a >> b[4:0];
            4'd8:    r = $signed(a) >>> b[4:0];
            4'd9:    r = ~(a | b);
            default: r = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic `ALU_OSIZE req0_op,
    input  logic `CPU_WSIZE req0_a,
    input  logic `CPU_WSIZE req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic `ALU_OSIZE req1_op,
    input  logic `CPU_WSIZE req1_a,
    input  logic `CPU_WSIZE req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic `CPU_WSIZE rsp_r,
    output logic            rsp_zero,
    output logic            rsp_ovf,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic `ALU_OSIZE op_q;
    logic `CPU_WSIZE a_q, b_q, r;
    logic id_q, last_grant, grant, zero, ovf;
    logic [3:0] cnt;

    alu u_alu (.r(r), .zero(zero), .ovf(ovf), .op(op_q), .a(a_q), .b(b_q));

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = !req0_valid;
`else
    assign grant = (req0_valid && req1_valid) ? !last_grant : !req0_valid;
`endif
    assign req0_ready = !rst && state == IDLE && req0_valid && !grant;
    assign req1_ready = !rst && state == IDLE && req1_valid && grant;
    assign busy = state != IDLE;

    // accept one op, hold it on the ALU for EXEC_CYCLES, then present the response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            id_q <= 1'b0;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_r <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    op_q <= grant ? req1_op : req0_op;
                    a_q <= grant ? req1_a : req0_a;
                    b_q <= grant ? req1_b : req0_b;
                    id_q <= grant;
                    last_grant <= grant;
                    cnt <= 4'(EXEC_CYCLES - 1);
                    state <= EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    rsp_r <= r;
                    rsp_zero <= zero;
                    rsp_ovf <= ovf;
                    rsp_id <= id_q;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector and sequence checks of alu_arbiter with EXEC_CYCLES 1 and 4
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk, rst, req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic d1_req0_ready, d1_req1_ready, d1_rsp_valid, d1_rsp_id, d1_rsp_zero, d1_rsp_ovf, d1_busy;
    logic d4_req0_ready, d4_req1_ready, d4_rsp_valid, d4_rsp_id, d4_rsp_zero, d4_rsp_ovf, d4_busy;
    logic [31:0] d1_rsp_r, d4_rsp_r;
    int total = 0;
    int bad = 0;

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id), .rsp_r(d1_rsp_r),
        .rsp_zero(d1_rsp_zero), .rsp_ovf(d1_rsp_ovf), .busy(d1_busy)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id), .rsp_r(d4_rsp_r),
        .rsp_zero(d4_rsp_zero), .rsp_ovf(d4_rsp_ovf), .busy(d4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic v0, v1;
        logic [3:0] op0;
        logic [31:0] a0, b0;
        logic [3:0] op1;
        logic [31:0] a1, b1;
        logic id;
        logic [31:0] r0;
        logic z0, o0;
        logic [31:0] r1;
        logic z1, o1;
    } vec_t;

    vec_t vt[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, want %b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    endtask

    initial begin
        vec_t v;
        logic eid;
        logic ids[4];
        logic [31:0] rs[4];
        int n;
        vt[0]  = '{1'b1, 1'b0, 4'd2, 32'd3, 32'd4, 4'd0, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 4'd2, 32'd10, 32'd20, 4'd2, 32'd0, 32'd0, 1'b1, 32'd30, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 4'd2, 32'd10, 32'd20, 4'd2, 32'd0, 32'd0, 1'b0, 32'd30, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd3, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd2, 32'h7fffffff, 32'd1, 1'b1, 32'd0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 4'd3, 32'h80000000, 32'd1, 4'd0, 32'd0, 32'd0, 1'b0, 32'h7fffffff, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 4'd0, 32'hf0f0, 32'hff00, 4'd1, 32'd1, 32'd2, 1'b1, 32'hf000, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 4'd4, 32'haaaa, 32'haaaa, 4'd1, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 4'd5, 32'hffffffff, 32'd1, 4'd0, 32'd0, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd6, 32'd1, 32'd4, 1'b1, 32'd0, 1'b0, 1'b0, 32'd16, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd8, 32'h80000000, 32'd4, 1'b1, 32'd0, 1'b0, 1'b0, 32'hf8000000, 1'b0, 1'b0};

        rst = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd2, 32'd1, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk1("rst_ready0", d1_req0_ready, 1'b0);
            chk1("rst_ready1", d1_req1_ready, 1'b0);
            chk1("rst_rsp_valid", d1_rsp_valid, 1'b0);
            chk1("rst_busy", d1_busy, 1'b0);
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        chk1("post_rst_ready0", d1_req0_ready, 1'b0);
        chk1("post_rst_ready1", d1_req1_ready, 1'b0);
        tick;
        chk1("post_rst_busy", d1_busy, 1'b0);
        chk1("post_rst_rsp_valid", d1_rsp_valid, 1'b0);

        rsp_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            v = vt[i];
            drive(v.v0, v.op0, v.a0, v.b0, v.v1, v.op1, v.a1, v.b1);
            #1;
            eid = (FIXED && v.v0 && v.v1) ? 1'b0 : v.id;
            chk1($sformatf("vec%0d_ready0", i), d1_req0_ready, v.v0 && !eid);
            chk1($sformatf("vec%0d_ready1", i), d1_req1_ready, v.v1 && eid);
            tick;
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
            chk1($sformatf("vec%0d_busy", i), d1_busy, 1'b1);
            chk1($sformatf("vec%0d_early_valid", i), d1_rsp_valid, 1'b0);
            tick;
            chk1($sformatf("vec%0d_rsp_valid", i), d1_rsp_valid, 1'b1);
            chk1($sformatf("vec%0d_id", i), d1_rsp_id, eid);
            chk32($sformatf("vec%0d_r", i), d1_rsp_r, eid ? v.r1 : v.r0);
            chk1($sformatf("vec%0d_zero", i), d1_rsp_zero, eid ? v.z1 : v.z0);
            chk1($sformatf("vec%0d_ovf", i), d1_rsp_ovf, eid ? v.o1 : v.o0);
            tick;
            chk1($sformatf("vec%0d_done_valid", i), d1_rsp_valid, 1'b0);
            chk1($sformatf("vec%0d_done_busy", i), d1_busy, 1'b0);
        end

        rsp_ready = 1'b0;
        drive(1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        chk1("bp_accept", d1_req0_ready, 1'b1);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'd9, 32'd9);
        tick;
        for (int k = 0; k < 5; k++) begin
            chk1("bp_valid", d1_rsp_valid, 1'b1);
            chk1("bp_id", d1_rsp_id, 1'b0);
            chk32("bp_r", d1_rsp_r, 32'd2);
            chk1("bp_ready1", d1_req1_ready, 1'b0);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        chk1("bp_hs_ready1", d1_req1_ready, 1'b0);
        tick;
        chk1("bp_after_valid", d1_rsp_valid, 1'b0);
        chk1("bp_after_ready1", d1_req1_ready, 1'b1);
        tick;
        req1_valid = 1'b0;
        tick;
        chk1("bp2_valid", d1_rsp_valid, 1'b1);
        chk1("bp2_id", d1_rsp_id, 1'b1);
        chk32("bp2_r", d1_rsp_r, 32'd18);
        tick;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(1'b1, 4'd2, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        chk1("mid_accept", d4_req0_ready, 1'b1);
        tick;
        req0_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rst = (j == 2);
            chk1("mid_no_rsp", d4_rsp_valid, 1'b0);
            tick;
        end
        chk1("mid_busy", d4_busy, 1'b0);
        drive(1'b1, 4'd2, 32'd5, 32'd6, 1'b1, 4'd2, 32'd7, 32'd8);
        #1;
        chk1("mid_tie_ready0", d4_req0_ready, 1'b1);
        chk1("mid_tie_ready1", d4_req1_ready, 1'b0);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk1("lat4_early", d4_rsp_valid, 1'b0);
            tick;
        end
        chk1("lat4_valid", d4_rsp_valid, 1'b1);
        chk1("lat4_id", d4_rsp_id, 1'b0);
        chk32("lat4_r", d4_rsp_r, 32'd11);
        tick;

        rst = 1'b1;
        drive(1'b1, 4'd2, 32'd100, 32'd0, 1'b1, 4'd2, 32'd200, 32'd0);
        tick;
        rst = 1'b0;
        #1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            chk1("fair_one_ready", d1_req0_ready && d1_req1_ready, 1'b0);
            if (d1_rsp_valid) begin
                ids[n] = d1_rsp_id;
                rs[n] = d1_rsp_r;
                n++;
            end
            tick;
        end
        chk32("fair_count", 32'(n), 32'd4);
        for (int k = 0; k < n; k++) begin
            eid = FIXED ? 1'b0 : k[0];
            chk1($sformatf("fair%0d_id", k), ids[k], eid);
            chk32($sformatf("fair%0d_r", k), rs[k], eid ? 32'd200 : 32'd100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
